sobel_gradient_unit: RTL and testbench
======================================

// Module: sobel_gradient_unit
// PURPOSE
//  Parametrised next-generation Sobel stage. Owns its two line buffers and 3x3 window, computes full-precision signed
//  Gx/Gy, and selects the magnitude metric at run time. Applies a programmable right-shift and threshold, and emits a
//  graded or binary edge map. Sits after the greyscale/filter stages and feeds the display/frame writer.
// PARAMETERS
//  PIXEL_W       8    pixel bit width (in and out)
//  IMAGE_WIDTH   640  active pixels per line; line buffer depth
//  IMAGE_HEIGHT  480  active lines per frame
//  COL_W         10   width of col input
//  ROW_W         10   width of row input
//  OUT_SHIFT     0    right-shift applied to magnitude before saturation (0..PIXEL_W+2)
// PORTS
//  clk             in   1        system clock, rising edge
//  reset           in   1        asynchronous, active-high
//  pixel_in        in   PIXEL_W  greyscale pixel, raster order
//  pixel_valid     in   1        pixel_in/col/row qualifier; gaps allowed
//  col             in   COL_W    column of pixel_in
//  row             in   ROW_W    row of pixel_in
//  mag_mode        in   2        00 L1 |gx|+|gy|; 01 max+min/2; 10 max(|gx|,|gy|); 11 treated as 00
//  binary_en       in   1        1: output all-ones/zero from threshold; 0: graded magnitude
//  threshold       in   PIXEL_W  edge threshold, compared to scaled magnitude
//  pixel_out       out  PIXEL_W  edge pixel
//  pixel_out_valid out  1        pixel_out/edge_flag qualifier
//  edge_flag       out  1        scaled magnitude > threshold
//  dir_out         out  2        quantised gradient direction (only with SOBEL_DIR_EN)
// BEHAVIOUR
//  - Reset: pixel_out=0, pixel_out_valid=0, edge_flag=0, dir_out=0, all pipeline valid bits cleared; line buffer RAM not cleared.
//  - Input order: strict raster; col 0..IMAGE_WIDTH-1, row 0..IMAGE_HEIGHT-1. Each accepted pixel is written to the line buffers.
//  - Emission: accepted pixel at (r,c) with r>=2 and c>=2 yields one output for centre (r-1,c-1).
//    Result: exactly (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2) outputs per frame; border pixels produce no output.
//  - Latency: fixed 4 cycles accept->pixel_out_valid. Pipeline advances every cycle; valid bits shift with data, so gaps propagate unchanged.
//  - Pipeline stages:
//    S1 window shift/line read; S2 signed Gx,Gy; S3 abs + metric; S4 shift, saturate, threshold.
//  - Arithmetic:
//    Gx,Gy signed PIXEL_W+3 bits, range +/-4*(2^PIXEL_W-1); abs values PIXEL_W+2 bits; metric PIXEL_W+3 bits, no overflow.
//    Mode 01 min/2 is truncating. scaled = metric>>OUT_SHIFT, saturated to 2^PIXEL_W-1.
//  - Output: edge_flag = scaled>threshold (strict). pixel_out = binary_en ? (edge_flag ? all-ones : 0) : scaled.
//  - Config latch: mag_mode, binary_en and threshold are sampled when (row,col)=(0,0) is accepted and held for that frame.
//    Changes mid-frame take effect at the next frame.
//  - New frame: accepting (0,0) restarts window fill. Stale line-buffer data never reaches an output, because emission requires r>=2.
//  - Reset mid-frame: outputs drop to 0 asynchronously. Nothing is emitted until a full fill of a new frame (r>=2, c>=2).
//  - Simultaneous frame wrap and in-flight outputs: the last outputs of frame N drain normally during the first pixels of frame N+1.
// CONFIGURATION
//  SOBEL_DIR_EN defined:
//    dir_out present, registered alongside pixel_out.
//    0 when |gy|*256 <= |gx|*106; else 2 when |gx|*256 <= |gy|*106; else 1 if sign(gx)==sign(gy), 3 otherwise.
//    Zero gradient gives 0.
//  SOBEL_DIR_EN undefined: dir_out port and its logic absent; all other behaviour identical.
// TESTING
//  - Flat 16x8 frame, all pixels 100, L1 -> 84 outputs, all pixel_out=0, edge_flag=0, first valid 4 cycles after (2,2) accept.
//  - Vertical step (c<4 ->0, else 200), PIXEL_W=8, OUT_SHIFT=0, L1 -> cols 3,4 pixel_out=255 (Gx=800 sat), others 0;
//    OUT_SHIFT=2 -> 200.
//  - Diagonal gx=gy=400, OUT_SHIFT=2 -> mode00 200, mode01 150, mode10 100; mode11 == mode00.
//  - binary_en=1, threshold=99 with scaled=100 -> 255/edge_flag=1; threshold=100 -> 0/edge_flag=0;
//    threshold written mid-frame has no effect until next (0,0).
//  - Random pixel_valid gaps (50%) -> output stream bit-identical to the gapless run; reset asserted at row 5 -> valid low
//    immediately, next frame correct.
//  - SOBEL_DIR_EN: vertical step -> dir_out=0; horizontal step -> 2; gx=gy>0 -> 1; gx=-gy -> 3.

Source files
------------

// File: rtl/sobel_gradient_unit.sv
// sobel_gradient_unit: line-buffered 3x3 Sobel stage with run-time magnitude metric, shift/saturate and threshold.
// Define SOBEL_DIR_EN to add the registered quantised-direction output dir_out.
module sobel_gradient_unit #(
    parameter int PIXEL_W      = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int COL_W        = 10,
    parameter int ROW_W        = 10,
    parameter int OUT_SHIFT    = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               pixel_valid,
    input  logic [COL_W-1:0]   col,
    input  logic [ROW_W-1:0]   row,
    input  logic [1:0]         mag_mode,
    input  logic               binary_en,
    input  logic [PIXEL_W-1:0] threshold,
`ifdef SOBEL_DIR_EN
    output logic [1:0]         dir_out,
`endif
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               pixel_out_valid,
    output logic               edge_flag
);
    localparam int GW = PIXEL_W + 3;
    localparam int AW = PIXEL_W + 2;
    localparam int MW = PIXEL_W + 3;
    localparam int LA = $clog2(IMAGE_WIDTH);
    localparam int CW = PIXEL_W + 3;
    localparam logic [PIXEL_W-1:0] PMAX = '1;

    logic [PIXEL_W-1:0] lb0 [IMAGE_WIDTH];
    logic [PIXEL_W-1:0] lb1 [IMAGE_WIDTH];
    logic [LA-1:0] wa;
    logic in_ok, frame_start, emit;
    logic [CW-1:0] cfg_q, cfg_d;
    logic [2:0][2:0][PIXEL_W-1:0] w_q, w_d;
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [1:0] mode1_q, mode1_d, mode2_q, mode2_d;
    logic [PIXEL_W:0] bt1_q, bt1_d, bt2_q, bt2_d, bt3_q, bt3_d;
    logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
    logic [AW-1:0] ax, ay, mx, mn;
    logic [MW-1:0] metric_q, metric_d, scaled;
    logic [PIXEL_W-1:0] sat, pout_q, pout_d;
    logic flag, flag_q, flag_d, vout_q, vout_d;

    function automatic logic signed [GW-1:0] tap(input logic [PIXEL_W-1:0] a, b, c);
        return GW'(a) + GW'({b, 1'b0}) + GW'(c);
    endfunction

    assign in_ok       = pixel_valid && 32'(col) < IMAGE_WIDTH && 32'(row) < IMAGE_HEIGHT;
    assign frame_start = in_ok && col == '0 && row == '0;
    assign emit        = in_ok && col >= COL_W'(2) && row >= ROW_W'(2);
    assign wa          = LA'(col);

    // Config travels with the data so the tail of a frame keeps its own settings.
    always_comb begin
        cfg_d = frame_start ? {mag_mode, binary_en, threshold} : cfg_q;
        w_d = w_q;
        if (in_ok) begin
            w_d[0] = {lb1[wa], w_q[0][2:1]};
            w_d[1] = {lb0[wa], w_q[1][2:1]};
            w_d[2] = {pixel_in, w_q[2][2:1]};
        end
        v1_d = emit;
        mode1_d = cfg_d[CW-1 -: 2];
        bt1_d = cfg_d[PIXEL_W:0];
        v2_d = v1_q;
        mode2_d = mode1_q;
        bt2_d = bt1_q;
        gx_d = tap(w_q[0][2], w_q[1][2], w_q[2][2]) - tap(w_q[0][0], w_q[1][0], w_q[2][0]);
        gy_d = tap(w_q[2][0], w_q[2][1], w_q[2][2]) - tap(w_q[0][0], w_q[0][1], w_q[0][2]);
        ax = AW'(gx_q[GW-1] ? -gx_q : gx_q);
        ay = AW'(gy_q[GW-1] ? -gy_q : gy_q);
        mx = ax > ay ? ax : ay;
        mn = ax > ay ? ay : ax;
        v3_d = v2_q;
        bt3_d = bt2_q;
        metric_d = mode2_q == 2'b01 ? MW'(mx) + MW'(mn >> 1) : mode2_q == 2'b10 ? MW'(mx) : MW'(ax) + MW'(ay);
        scaled = metric_q >> OUT_SHIFT;
        sat = scaled > MW'(PMAX) ? PMAX : scaled[PIXEL_W-1:0];
        flag = sat > bt3_q[PIXEL_W-1:0];
        vout_d = v3_q;
        flag_d = v3_q && flag;
        pout_d = !v3_q ? '0 : bt3_q[PIXEL_W] ? (flag ? PMAX : '0) : sat;
    end

    always_ff @(posedge clk) begin
        if (in_ok) begin
            lb0[wa] <= pixel_in;
            lb1[wa] <= lb0[wa];
        end
        w_q <= w_d;
        mode1_q <= mode1_d;
        mode2_q <= mode2_d;
        bt1_q <= bt1_d;
        bt2_q <= bt2_d;
        bt3_q <= bt3_d;
        gx_q <= gx_d;
        gy_q <= gy_d;
        metric_q <= metric_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            pout_q <= '0;
            vout_q <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            cfg_q <= cfg_d;
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            pout_q <= pout_d;
            vout_q <= vout_d;
            flag_q <= flag_d;
        end
    end

    assign pixel_out       = pout_q;
    assign pixel_out_valid = vout_q;
    assign edge_flag       = flag_q;

`ifdef SOBEL_DIR_EN
    localparam int DW = AW + 8;
    logic [1:0] dir3_q, dir3_d, dir_q, dir_d;
    logic [DW-1:0] sx, sy, kx, ky;

    // tan(22.5 deg) ~= 106/256
    always_comb begin
        sx = {ax, 8'b0};
        sy = {ay, 8'b0};
        kx = DW'(ax) * DW'(106);
        ky = DW'(ay) * DW'(106);
        dir3_d = sy <= kx ? 2'd0 : sx <= ky ? 2'd2 : gx_q[GW-1] == gy_q[GW-1] ? 2'd1 : 2'd3;
        dir_d = v3_q ? dir3_q : 2'd0;
    end

    always_ff @(posedge clk) dir3_q <= dir3_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) dir_q <= 2'd0;
        else dir_q <= dir_d;
    end

    assign dir_out = dir_q;
`endif
endmodule

// File: tb/tb_sobel_gradient_unit.sv
// tb_sobel_gradient_unit: scoreboard bench for sobel_gradient_unit on a 16x8 frame with OUT_SHIFT=2.
module tb_sobel_gradient_unit;
    localparam int PW = 8;
    localparam int W  = 16;
    localparam int H  = 8;
    localparam int SH = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [PW-1:0] pixel_in = '0;
    logic pixel_valid = 1'b0;
    logic [9:0] col = '0;
    logic [9:0] row = '0;
    logic [1:0] mag_mode = '0;
    logic binary_en = 1'b0;
    logic [PW-1:0] threshold = '0;
    logic [PW-1:0] pixel_out;
    logic pixel_out_valid, edge_flag;

    typedef struct {int r; int c; int pix; int flag; int cyc;} exp_t;
    exp_t q[$];
    int errors = 0, checks = 0, cyc = 0, nout = 0;
    int got[H][W];
    int m_mode = 0, m_bin = 0, m_thr = 0;
    int dg[4] = '{200, 150, 100, 200};

    sobel_gradient_unit #(.PIXEL_W(PW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .COL_W(10), .ROW_W(10), .OUT_SHIFT(SH)) dut (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .col(col), .row(row),
        .mag_mode(mag_mode), .binary_en(binary_en), .threshold(threshold),
        .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid), .edge_flag(edge_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int pix(input int pat, input int r, input int c);
        case (pat)
            0: return 100;
            1: return c < 4 ? 0 : 200;
            2: return 50 * (r + c) > 255 ? 255 : 50 * (r + c);
            default: return (r * 37 + c * 91 + r * c * 13) % 256;
        endcase
    endfunction

    function automatic exp_t model(input int pat, input int r, input int c);
        int gx, gy, ax, ay, mx, mn, m, s;
        exp_t e;
        gx = pix(pat, r-1, c+1) + 2 * pix(pat, r, c+1) + pix(pat, r+1, c+1)
           - pix(pat, r-1, c-1) - 2 * pix(pat, r, c-1) - pix(pat, r+1, c-1);
        gy = pix(pat, r+1, c-1) + 2 * pix(pat, r+1, c) + pix(pat, r+1, c+1)
           - pix(pat, r-1, c-1) - 2 * pix(pat, r-1, c) - pix(pat, r-1, c+1);
        ax = gx < 0 ? -gx : gx;
        ay = gy < 0 ? -gy : gy;
        mx = ax > ay ? ax : ay;
        mn = ax > ay ? ay : ax;
        m = m_mode == 1 ? mx + mn / 2 : m_mode == 2 ? mx : ax + ay;
        s = m >> SH;
        if (s > 255) s = 255;
        e.flag = s > m_thr ? 1 : 0;
        e.pix = m_bin != 0 ? (e.flag != 0 ? 255 : 0) : s;
        e.r = r;
        e.c = c;
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (pixel_out_valid) begin
            if (q.size() == 0) chk("spurious_output", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("pixel_out(%0d,%0d)", e.r, e.c), int'(pixel_out), e.pix);
                chk($sformatf("edge_flag(%0d,%0d)", e.r, e.c), int'(edge_flag), e.flag);
                chk($sformatf("latency(%0d,%0d)", e.r, e.c), cyc, e.cyc);
                got[e.r][e.c] = int'(pixel_out);
                nout++;
            end
        end
    end

    task automatic send_frame(input int pat, input int mode, input int bin, input int thr,
                              input int gap, input int thr_mid, input int rst_row);
        exp_t e;
        foreach (got[i, j]) got[i][j] = -1;
        mag_mode = 2'(mode);
        binary_en = 1'(bin);
        threshold = PW'(thr);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == rst_row && c == 0) begin
                    pixel_valid = 1'b0;
                    reset = 1'b1;
                    #1;
                    chk("async_reset_valid", int'(pixel_out_valid), 0);
                    chk("async_reset_pix", int'(pixel_out), 0);
                    q.delete();
                    repeat (2) @(posedge clk);
                    #1;
                    reset = 1'b0;
                    return;
                end
                while (int'($urandom_range(99)) < gap) begin
                    pixel_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                pixel_in = PW'(pix(pat, r, c));
                col = 10'(c);
                row = 10'(r);
                pixel_valid = 1'b1;
                if (r == 0 && c == 0) begin
                    m_mode = mode;
                    m_bin = bin;
                    m_thr = thr;
                end
                if (r == 1 && c == 5 && thr_mid >= 0) threshold = PW'(thr_mid);
                if (r >= 2 && c >= 2) begin
                    e = model(pat, r - 1, c - 1);
                    e.cyc = cyc + 4;
                    q.push_back(e);
                end
                @(posedge clk);
                #1;
            end
        end
        pixel_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", q.size(), 0);
        q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", int'(pixel_out_valid), 0);
        chk("reset_pix", int'(pixel_out), 0);
        chk("reset_flag", int'(edge_flag), 0);
        reset = 1'b0;
        send_frame(0, 0, 0, 0, 0, -1, -1);
        drain();
        chk("flat_count", nout, 84);
        chk("flat_pix", got[3][7], 0);
        send_frame(1, 0, 0, 0, 0, -1, -1);
        drain();
        for (int c = 1; c < W - 1; c++) chk($sformatf("vstep_col%0d", c), got[3][c], (c == 3 || c == 4) ? 200 : 0);
        for (int m = 0; m < 4; m++) begin
            send_frame(2, m, 0, 255, 0, -1, -1);
            drain();
            chk($sformatf("diag_mode%0d", m), got[1][1], dg[m]);
        end
        send_frame(2, 2, 1, 99, 0, -1, -1);
        drain();
        chk("bin_thr99", got[1][1], 255);
        send_frame(2, 2, 1, 100, 0, -1, -1);
        drain();
        chk("bin_thr100", got[1][1], 0);
        send_frame(2, 2, 1, 99, 0, 200, -1);
        drain();
        chk("thr_midframe_held", got[1][1], 255);
        send_frame(3, 1, 0, 50, 0, -1, -1);
        send_frame(3, 0, 1, 120, 50, -1, -1);
        drain();
        send_frame(3, 0, 0, 30, 0, -1, 5);
        send_frame(1, 0, 0, 0, 50, -1, -1);
        drain();
        chk("post_reset_col3", got[3][3], 200);
        chk("post_reset_col5", got[3][5], 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
